// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between Icache refill bursts and Dcache accesses.
// Optional feature: define ARB_RR_EN for round-robin tie-breaking (default: Dcache priority).
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic                  ic_gnt_o,
  output logic                  ic_rvalid_o,
  output logic [DATA_WIDTH-1:0] ic_rdata_o,
  output logic                  ic_last_o,
  input  logic                  dc_req_i,
  input  logic                  dc_we_i,
  input  logic                  dc_burst_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [DATA_WIDTH-1:0] dc_wdata_i,
  output logic                  dc_gnt_o,
  output logic                  dc_ack_o,
  output logic [DATA_WIDTH-1:0] dc_rdata_o,
  output logic                  dc_last_o,
  input  logic                  flush_req_i,
  output logic                  flush_done_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  localparam int unsigned BeatW = $clog2(BURST_LEN);
  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned LineW = $clog2(BURST_LEN * Bytes);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIcXfer = 2'd1;
  localparam logic [1:0] StDcXfer = 2'd2;

  logic [1:0]            stateQ, stateD;
  logic [BeatW-1:0]      beatQ, beatD;
  logic [ADDR_WIDTH-1:0] baseQ;
  logic [DATA_WIDTH-1:0] wdataQ;
  logic                  weQ;
  logic                  burstQ;
  logic                  icGntQ;
  logic                  dcGntQ;
  logic                  flushDoneQ;

  logic                  grantIc;
  logic                  grantDc;
  logic                  busy;
  logic                  icOwn;
  logic                  dcOwn;
  logic                  lastBeat;
  logic [LineW-1:0]      lineOff;
  logic [ADDR_WIDTH-1:0] beatAddr;

`ifdef ARB_RR_EN
  logic lastOwnerIcQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastOwnerIcQ <= 1'b0;
    end else if (grantIc) begin
      lastOwnerIcQ <= 1'b1;
    end else if (grantDc) begin
      lastOwnerIcQ <= 1'b0;
    end
  end
`endif

  // Grants only from IDLE; a pending flush blocks every new grant.
  always_comb begin
    grantIc = 1'b0;
    grantDc = 1'b0;
    if (stateQ == StIdle && !flush_req_i) begin
`ifdef ARB_RR_EN
      if (ic_req_i && dc_req_i) begin
        grantIc = !lastOwnerIcQ;
        grantDc = lastOwnerIcQ;
      end else begin
        grantIc = ic_req_i;
        grantDc = dc_req_i;
      end
`else
      grantDc = dc_req_i;
      grantIc = ic_req_i && !dc_req_i;
`endif
    end
  end

  assign lastBeat = burstQ ? (beatQ == BeatW'(BURST_LEN - 1)) : 1'b1;

  always_comb begin
    stateD = stateQ;
    beatD  = beatQ;
    unique case (stateQ)
      StIdle: begin
        beatD = '0;
        if (grantIc) begin
          stateD = StIcXfer;
        end else if (grantDc) begin
          stateD = StDcXfer;
        end
      end
      StIcXfer, StDcXfer: begin
        if (bus_ack_i) begin
          if (lastBeat) begin
            stateD = StIdle;
            beatD  = '0;
          end else begin
            beatD = beatQ + 1'b1;
          end
        end
      end
      default: begin
        stateD = StIdle;
        beatD  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= StIdle;
      beatQ      <= '0;
      baseQ      <= '0;
      wdataQ     <= '0;
      weQ        <= 1'b0;
      burstQ     <= 1'b0;
      icGntQ     <= 1'b0;
      dcGntQ     <= 1'b0;
      flushDoneQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      beatQ      <= beatD;
      icGntQ     <= grantIc;
      dcGntQ     <= grantDc;
      flushDoneQ <= (stateQ == StIdle) && flush_req_i;
      if (grantIc) begin
        baseQ  <= ic_addr_i;
        wdataQ <= '0;
        weQ    <= 1'b0;
        burstQ <= 1'b1;
      end else if (grantDc) begin
        baseQ  <= dc_addr_i;
        wdataQ <= dc_we_i ? dc_wdata_i : '0;
        weQ    <= dc_we_i;
        burstQ <= !dc_we_i && dc_burst_i;
      end
    end
  end

  // Beat offset wraps inside the burst-aligned line; upper address bits stay fixed.
  assign lineOff  = baseQ[LineW-1:0] + LineW'(beatQ) * LineW'(Bytes);
  assign beatAddr = {baseQ[ADDR_WIDTH-1:LineW], lineOff};

  assign busy  = (stateQ != StIdle);
  assign icOwn = (stateQ == StIcXfer);
  assign dcOwn = (stateQ == StDcXfer);

  assign bus_req_o   = busy;
  assign bus_we_o    = dcOwn && weQ;
  assign bus_addr_o  = busy ? beatAddr : '0;
  assign bus_wdata_o = (dcOwn && weQ) ? wdataQ : '0;

  assign ic_gnt_o    = icGntQ;
  assign ic_rvalid_o = icOwn && bus_ack_i;
  assign ic_rdata_o  = ic_rvalid_o ? bus_rdata_i : '0;
  assign ic_last_o   = ic_rvalid_o && lastBeat;

  assign dc_gnt_o    = dcGntQ;
  assign dc_ack_o    = dcOwn && bus_ack_i;
  assign dc_rdata_o  = (dc_ack_o && !weQ) ? bus_rdata_i : '0;
  assign dc_last_o   = dc_ack_o && lastBeat;

  assign flush_done_o = flushDoneQ;

`ifndef SYNTHESIS
  gntOneHot: assert property (@(posedge clk) disable iff (rst) !(icGntQ && dcGntQ));
  gntFromIdle: assert property (@(posedge clk) disable iff (rst) (icGntQ || dcGntQ) |-> busy);
`endif

endmodule
